lms_ctr_fpga_spi_slave: RTL and testbench

SPI slave (responder) peripheral for the lms_ctr control subsystem: the far end of the 8-bit SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. It oversamples an external SCLK/SS_n/MOSI on the system clock, shifts a CPU-supplied byte out on MISO and presents each received byte to the CPU through the same register map, status bits, streaming flags and IRQ scheme as the master core.

---
 rtl/lms_ctr_fpga_spi_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_lms_ctr_fpga_spi_slave.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_ctr_fpga_spi_slave.sv
// SPI mode-0 slave (MSB first) with master-compatible CPU register map, status and IRQ.
// Define LMS_SPIS_EOP_EN to enable the end-of-packet value register (addr 6) and EOP flag.
module lms_ctr_fpga_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic [15:0] data_to_cpu,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket,
    output logic        irq
);

`ifdef LMS_SPIS_EOP_EN
    localparam logic [15:0] CTRL_MASK = 16'h03DC;
    localparam logic        EOP_EN    = 1'b1;
`else
    localparam logic [15:0] CTRL_MASK = 16'h01DC;
    localparam logic        EOP_EN    = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sclk_d, r_ss_d;
    logic                   w_sclk, w_ss, w_mosi, w_sclk_rise, w_sclk_fall, w_ss_fall;

    state_t      r_state;
    logic [7:0]  r_shift, r_tx_hold, r_rx_hold;
    logic [3:0]  r_bitcnt;
    logic        r_mosi_bit, r_oe;
    logic        r_trdy, r_rrdy, r_roe, r_toe, r_tur, r_eop, r_irq;
    logic [15:0] r_ctrl, r_eop_val, r_dout;
    logic        r_rd_req_d, r_wr_req_d, r_wr_pend;
    logic [2:0]  r_wr_addr;

    logic        w_rd_strobe, w_wr_strobe, w_rd_rx;
    logic        w_wr_tx, w_wr_status, w_wr_ctrl, w_wr_eop;
    logic [7:0]  w_rx_byte, w_load_byte;
    logic        w_tmt;
    logic [15:0] w_status, w_rd_mux;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_ss_fall   = ~w_ss & r_ss_d;

    assign w_rd_strobe = spi_select & ~read_n & ~r_rd_req_d;
    assign w_wr_strobe = spi_select & ~write_n & ~r_wr_req_d;
    assign w_rd_rx     = w_rd_strobe & (mem_addr == 3'd0);
    assign w_wr_tx     = r_wr_pend & (r_wr_addr == 3'd1);
    assign w_wr_status = r_wr_pend & (r_wr_addr == 3'd2);
    assign w_wr_ctrl   = r_wr_pend & (r_wr_addr == 3'd3);
    assign w_wr_eop    = r_wr_pend & (r_wr_addr == 3'd6) & EOP_EN;

    assign w_rx_byte   = {r_shift[6:0], w_mosi};
    assign w_load_byte = r_trdy ? 8'h00 : r_tx_hold;
    assign w_tmt       = (r_state == ST_IDLE) & r_trdy;
    assign w_status    = {6'd0, r_eop, r_toe | r_roe, r_rrdy, r_trdy, w_tmt,
                          r_toe, r_roe, r_tur, 2'd0};

    assign MISO          = r_shift[7];
    assign MISO_oe       = r_oe;
    assign data_to_cpu   = r_dout;
    assign dataavailable = r_rrdy;
    assign readyfordata  = r_trdy;
    assign endofpacket   = r_eop;
    assign irq           = r_irq;

    // Resynchronise the SPI pins and keep previous values for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_ss_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk;
            r_ss_d      <= w_ss;
        end
    end

    // CPU access strobes: one per assertion, write data taken on the following cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_req_d <= 1'b0;
            r_wr_req_d <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_wr_addr  <= 3'd0;
        end else begin
            r_rd_req_d <= spi_select & ~read_n;
            r_wr_req_d <= spi_select & ~write_n;
            r_wr_pend  <= w_wr_strobe;
            if (w_wr_strobe) begin
                r_wr_addr <= mem_addr;
            end
        end
    end

    // Transfer FSM plus status flags; CPU clears come first so hardware sets win
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'h00;
            r_tx_hold  <= 8'h00;
            r_rx_hold  <= 8'h00;
            r_bitcnt   <= 4'd0;
            r_mosi_bit <= 1'b0;
            r_oe       <= 1'b0;
            r_trdy     <= 1'b1;
            r_rrdy     <= 1'b0;
            r_roe      <= 1'b0;
            r_toe      <= 1'b0;
            r_tur      <= 1'b0;
            r_eop      <= 1'b0;
            r_ctrl     <= 16'h0000;
            r_eop_val  <= 16'h0000;
        end else begin
            if (w_rd_rx) begin
                r_rrdy <= 1'b0;
            end
            if (w_wr_status) begin
                r_eop  <= 1'b0;
                r_rrdy <= 1'b0;
                r_roe  <= 1'b0;
                r_toe  <= 1'b0;
                r_tur  <= 1'b0;
            end
            if (w_wr_tx) begin
                if (r_trdy) begin
                    r_tx_hold <= data_from_cpu[7:0];
                    r_trdy    <= 1'b0;
                    if (EOP_EN && (data_from_cpu[7:0] == r_eop_val[7:0])) begin
                        r_eop <= 1'b1;
                    end
                end else begin
                    r_toe <= 1'b1;
                end
            end
            if (w_wr_ctrl) begin
                r_ctrl <= data_from_cpu & CTRL_MASK;
            end
            if (w_wr_eop) begin
                r_eop_val <= data_from_cpu;
            end

            if (w_ss) begin
                r_state  <= ST_IDLE;
                r_shift  <= 8'h00;
                r_bitcnt <= 4'd0;
                r_oe     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall) begin
                            r_state <= ST_LOAD;
                            r_oe    <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        r_shift  <= w_load_byte;
                        r_bitcnt <= 4'd0;
                        if (r_trdy) r_tur  <= 1'b1;
                        else        r_trdy <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_sclk_rise) begin
                            r_mosi_bit <= w_mosi;
                            r_bitcnt   <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                r_rx_hold <= w_rx_byte;
                                r_rrdy    <= 1'b1;
                                if (r_rrdy) r_roe <= 1'b1;
                                if (EOP_EN && (w_rx_byte == r_eop_val[7:0])) begin
                                    r_eop <= 1'b1;
                                end
                            end
                        end else if (w_sclk_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_shift  <= w_load_byte;
                                r_bitcnt <= 4'd0;
                                if (r_trdy) r_tur  <= 1'b1;
                                else        r_trdy <= 1'b1;
                            end else begin
                                r_shift <= {r_shift[6:0], r_mosi_bit};
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Read-data mux, registered every cycle from the current address
    always_comb begin
        w_rd_mux = 16'h0000;
        case (mem_addr)
            3'd0:    w_rd_mux = {8'h00, r_rx_hold};
            3'd2:    w_rd_mux = w_status;
            3'd3:    w_rd_mux = r_ctrl;
            3'd6:    w_rd_mux = EOP_EN ? r_eop_val : 16'h0000;
            default: w_rd_mux = 16'h0000;
        endcase
    end

    // Registered read data and interrupt (status and control bits share positions)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= 16'h0000;
            r_irq  <= 1'b0;
        end else begin
            r_dout <= w_rd_mux;
            r_irq  <= |(w_status & r_ctrl);
        end
    end

endmodule

// File: tb/tb_lms_ctr_fpga_spi_slave.sv
// Directed plus randomized bench for lms_ctr_fpga_spi_slave against a transaction-level model.
module tb_lms_ctr_fpga_spi_slave;

`ifdef LMS_SPIS_EOP_EN
    localparam bit          EOP_ON   = 1'b1;
    localparam logic [15:0] CTRL_MSK = 16'h03DC;
`else
    localparam bit          EOP_ON   = 1'b0;
    localparam logic [15:0] CTRL_MSK = 16'h01DC;
`endif

    logic        clk = 1'b0;
    logic        reset_n, SCLK, SS_n, MOSI, MISO, MISO_oe;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        read_n, write_n, spi_select;
    logic        dataavailable, readyfordata, endofpacket, irq;

    int errors = 0;
    int checks = 0;

    // transaction-level model state
    logic        m_primed, m_rrdy, m_roe, m_toe, m_tur, m_eop;
    logic [7:0]  m_hold, m_rx, m_shift;
    logic [15:0] m_ctrl, m_eopv;
    logic [7:0]  mosi_q[$];

    lms_ctr_fpga_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr),
        .data_from_cpu(data_from_cpu), .read_n(read_n), .write_n(write_n),
        .spi_select(spi_select), .data_to_cpu(data_to_cpu),
        .dataavailable(dataavailable), .readyfordata(readyfordata),
        .endofpacket(endofpacket), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic do_check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
            $error("check %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s = 16'h0000;
        s[9] = m_eop;
        s[8] = m_roe | m_toe;
        s[7] = m_rrdy;
        s[6] = ~m_primed;
        s[5] = ~m_primed;
        s[4] = m_toe;
        s[3] = m_roe;
        s[2] = m_tur;
        return s;
    endfunction

    function automatic logic exp_irq();
        return (m_eop & m_ctrl[9]) | ((m_roe | m_toe) & m_ctrl[8]) | (m_rrdy & m_ctrl[7]) |
               (~m_primed & m_ctrl[6]) | (m_toe & m_ctrl[4]) | (m_roe & m_ctrl[3]) |
               (m_tur & m_ctrl[2]);
    endfunction

    task automatic m_load();
        if (m_primed) begin
            m_shift  = m_hold;
            m_primed = 1'b0;
        end else begin
            m_shift = 8'h00;
            m_tur   = 1'b1;
        end
    endtask

    task automatic m_receive(input logic [7:0] b);
        if (m_rrdy) m_roe = 1'b1;
        m_rrdy = 1'b1;
        m_rx   = b;
        if (EOP_ON && (b == m_eopv[7:0])) m_eop = 1'b1;
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1; mem_addr = 3'd0;
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        @(negedge clk);
        d = data_to_cpu;
        spi_select = 1'b0; read_n = 1'b1; mem_addr = 3'd0;
        @(negedge clk);
    endtask

    task automatic cpu_tx(input logic [7:0] b);
        cpu_write(3'd1, {8'h00, b});
        if (!m_primed) begin
            m_hold   = b;
            m_primed = 1'b1;
            if (EOP_ON && (b == m_eopv[7:0])) m_eop = 1'b1;
        end else begin
            m_toe = 1'b1;
        end
    endtask

    task automatic status_clear();
        cpu_write(3'd2, 16'hFFFF);
        m_eop = 1'b0; m_rrdy = 1'b0; m_roe = 1'b0; m_toe = 1'b0; m_tur = 1'b0;
    endtask

    task automatic rx_read(input string tag);
        logic [15:0] d;
        cpu_read(3'd0, d);
        do_check(tag, d, {8'h00, m_rx});
        m_rrdy = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [15:0] d;
        cpu_read(3'd2, d);
        do_check({tag, "_status"}, d, exp_status());
        @(negedge clk);
        do_check({tag, "_irq"}, {15'd0, irq}, {15'd0, exp_irq()});
        do_check({tag, "_rrdy_pin"}, {15'd0, dataavailable}, {15'd0, m_rrdy});
        do_check({tag, "_trdy_pin"}, {15'd0, readyfordata}, {15'd0, ~m_primed});
        do_check({tag, "_eop_pin"}, {15'd0, endofpacket}, {15'd0, m_eop});
    endtask

    // sends every queued byte (checking MISO), then 'partial' extra SCLK cycles, then deselects
    task automatic spi_xfer(input int partial);
        logic [7:0] b, got, exp;
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        do_check("miso_oe_sel", {15'd0, MISO_oe}, 16'd1);
        m_load();
        while (mosi_q.size() > 0) begin
            b   = mosi_q.pop_front();
            exp = m_shift;
            got = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                MOSI = b[i];
                repeat (4) @(negedge clk);
                got[i] = MISO;
                SCLK = 1'b1;
                repeat (4) @(negedge clk);
                SCLK = 1'b0;
            end
            do_check("miso_byte", {8'h00, got}, {8'h00, exp});
            m_receive(b);
            m_load();
        end
        for (int i = 0; i < partial; i++) begin
            MOSI = 1'($urandom);
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        repeat (4) @(negedge clk);
        do_check("miso_oe_rel", {15'd0, MISO_oe}, 16'd0);
        do_check("miso_idle", {15'd0, MISO}, 16'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] d, cv;
        int nw, nb;
        reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        mem_addr = 3'd0; data_from_cpu = 16'h0000;
        read_n = 1'b1; write_n = 1'b1; spi_select = 1'b0;
        m_primed = 1'b0; m_rrdy = 1'b0; m_roe = 1'b0; m_toe = 1'b0; m_tur = 1'b0;
        m_eop = 1'b0; m_hold = 8'h00; m_rx = 8'h00; m_shift = 8'h00;
        m_ctrl = 16'h0000; m_eopv = 16'h0000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        do_check("rst_dout", data_to_cpu, 16'h0000);
        do_check("rst_miso", {15'd0, MISO}, 16'd0);
        do_check("rst_oe", {15'd0, MISO_oe}, 16'd0);
        do_check("rst_irq", {15'd0, irq}, 16'd0);
        do_check("rst_rrdy", {15'd0, dataavailable}, 16'd0);
        do_check("rst_trdy", {15'd0, readyfordata}, 16'd1);
        do_check("rst_eop", {15'd0, endofpacket}, 16'd0);
        cpu_read(3'd2, d);
        do_check("rst_status", d, 16'h0060);
        cpu_read(3'd4, d); do_check("addr4", d, 16'h0000);
        cpu_read(3'd5, d); do_check("addr5", d, 16'h0000);
        cpu_read(3'd7, d); do_check("addr7", d, 16'h0000);

        cpu_write(3'd3, 16'hFFFF);
        cpu_read(3'd3, d);
        do_check("ctrl_mask", d, CTRL_MSK);
        cpu_write(3'd3, 16'h0004);
        m_ctrl = 16'h0004;
        cpu_read(3'd3, d);
        do_check("ctrl_itur", d, 16'h0004);

        // tx 0xA5 while master sends 0x3C
        cpu_tx(8'hA5);
        do_check("trdy_primed", {15'd0, readyfordata}, 16'd0);
        mosi_q.push_back(8'h3C);
        spi_xfer(0);
        check_state("a5");
        rx_read("rx_3c");
        check_state("a5_rd");

        // underrun: no tx primed
        status_clear();
        check_state("clr1");
        mosi_q.push_back(8'h81);
        spi_xfer(0);
        check_state("tur");
        status_clear();
        check_state("clr2");

        // back-to-back bytes without rx read, and a tx write while primed
        cpu_tx(8'h11);
        cpu_tx(8'h22);
        mosi_q.push_back(8'hC3);
        mosi_q.push_back(8'h5A);
        spi_xfer(0);
        check_state("b2b");
        rx_read("rx_5a");
        status_clear();

        // partial byte then a clean full byte
        cpu_tx(8'h99);
        spi_xfer(5);
        check_state("partial");
        cpu_tx(8'h6B);
        mosi_q.push_back(8'hE7);
        spi_xfer(0);
        check_state("after_partial");
        rx_read("rx_e7");
        status_clear();

`ifdef LMS_SPIS_EOP_EN
        cpu_write(3'd6, 16'h007E);
        m_eopv = 16'h007E;
        cpu_read(3'd6, d);
        do_check("eop_val", d, 16'h007E);
        mosi_q.push_back(8'h7E);
        spi_xfer(0);
        check_state("eop_rx");
        rx_read("rx_7e");
        status_clear();
`else
        cpu_write(3'd6, 16'h007E);
        cpu_read(3'd6, d);
        do_check("eop_off", d, 16'h0000);
        mosi_q.push_back(8'h7E);
        spi_xfer(0);
        check_state("eop_off_rx");
        rx_read("rx_7e");
        status_clear();
`endif

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                cv = 16'($urandom);
                cpu_write(3'd3, cv);
                m_ctrl = cv & CTRL_MSK;
            end
            nw = int'($urandom_range(0, 2));
            for (int k = 0; k < nw; k++) cpu_tx(8'($urandom));
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < nb; k++) mosi_q.push_back(8'($urandom));
            spi_xfer(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7)));
            check_state("rnd");
            if ($urandom_range(0, 1) == 1) rx_read("rnd_rx");
            if ($urandom_range(0, 2) == 0) status_clear();
        end
        check_state("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
